// File: rtl/mmp_mix_sat.sv
// Three-source audio mixer: per-source gain and saturation, computed on one shared
// multiplier over four clocks. Strobes that arrive mid-mix are dropped and flagged.
module mmp_mix_sat #(
  parameter int GAIN_SHIFT = 4
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_SMPL_STB,
  input  logic signed [15:0] i_SCC,
  input  logic signed [15:0] i_PSG,
  input  logic signed [15:0] i_OPLL,
  input  logic        [4:0]  i_VOL_SCC,
  input  logic        [4:0]  i_VOL_PSG,
  input  logic        [4:0]  i_VOL_OPLL,
  input  logic               i_MUTE,
  input  logic               i_OVR_CLR,
  output logic signed [15:0] o_SCC,
  output logic signed [15:0] o_PSG,
  output logic signed [15:0] o_OPLL,
  output logic signed [15:0] o_ALL,
  output logic               o_VALID,
  output logic               o_BUSY,
  output logic               o_OVR
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, SAT} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] scc_q, psg_q, opll_q;
  logic        [4:0]  g_scc_q, g_psg_q, g_opll_q;
  logic               mute_q;
  logic signed [23:0] acc_q, acc_d;
  logic signed [15:0] out_scc_q, out_psg_q, out_opll_q, all_q;
  logic               valid_q, ovr_q;

  logic signed [15:0] mul_smp;
  logic        [4:0]  mul_gain, gain_eff;
  logic signed [23:0] mul_a, mul_b, prod;
  logic signed [23:0] shd;
  logic signed [15:0] clamp_val;
  logic               accept, ovr_set;

  assign accept  = (state_q == IDLE) && i_SMPL_STB;
  assign ovr_set = (state_q != IDLE) && i_SMPL_STB;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_SMPL_STB) state_d = MUL0;
      MUL0:    state_d = MUL1;
      MUL1:    state_d = MUL2;
      MUL2:    state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The single multiplier walks through the latched sources in MUL0..MUL2.
  always_comb begin
    mul_smp  = scc_q;
    mul_gain = g_scc_q;
    case (state_q)
      MUL1: begin mul_smp = psg_q;  mul_gain = g_psg_q;  end
      MUL2: begin mul_smp = opll_q; mul_gain = g_opll_q; end
      default: ;
    endcase
  end

  assign gain_eff = (mul_gain > 5'd16) ? 5'd16 : mul_gain;
  assign mul_a    = {{8{mul_smp[15]}}, mul_smp};
  assign mul_b    = $signed({19'b0, gain_eff});
  assign prod     = mul_a * mul_b;

  always_comb begin
    acc_d = acc_q;
    case (state_q)
      MUL0:       acc_d = prod;
      MUL1, MUL2: acc_d = acc_q + prod;
      default: ;
    endcase
  end

  // Arithmetic shift floors toward minus infinity; then clamp to 16 bits.
  assign shd = acc_q >>> GAIN_SHIFT;
  always_comb begin
    if (shd > 24'sd32767)        clamp_val = 16'sh7fff;
    else if (shd < -24'sd32768)  clamp_val = 16'sh8000;
    else                         clamp_val = shd[15:0];
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= IDLE;
      scc_q      <= '0;
      psg_q      <= '0;
      opll_q     <= '0;
      g_scc_q    <= '0;
      g_psg_q    <= '0;
      g_opll_q   <= '0;
      mute_q     <= 1'b0;
      acc_q      <= '0;
      out_scc_q  <= '0;
      out_psg_q  <= '0;
      out_opll_q <= '0;
      all_q      <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      valid_q <= (state_q == SAT);
      if (accept) begin
        scc_q    <= i_SCC;
        psg_q    <= i_PSG;
        opll_q   <= i_OPLL;
        g_scc_q  <= i_VOL_SCC;
        g_psg_q  <= i_VOL_PSG;
        g_opll_q <= i_VOL_OPLL;
        mute_q   <= i_MUTE;
      end
      if (state_q == SAT) begin
        out_scc_q  <= scc_q;
        out_psg_q  <= psg_q;
        out_opll_q <= opll_q;
        all_q      <= mute_q ? 16'sd0 : clamp_val;
      end
      // A new overrun beats a simultaneous clear.
      if (ovr_set)        ovr_q <= 1'b1;
      else if (i_OVR_CLR) ovr_q <= 1'b0;
    end
  end

  assign o_SCC   = out_scc_q;
  assign o_PSG   = out_psg_q;
  assign o_OPLL  = out_opll_q;
  assign o_ALL   = all_q;
  assign o_VALID = valid_q;
  assign o_BUSY  = (state_q != IDLE);
  assign o_OVR   = ovr_q;

endmodule

// File: tb/tb_mmp_mix_sat.sv
// Scoreboard bench for mmp_mix_sat: the driver queues expected mixes from an
// integer reference model, and a negedge monitor checks each o_VALID pulse.
module tb_mmp_mix_sat;

  localparam int GS = 4;

  logic clk = 1'b0, rst = 1'b1, stb = 1'b0, mute = 1'b0, ovr_clr = 1'b0;
  logic signed [15:0] scc = '0, psg = '0, opll = '0;
  logic [4:0] vs = '0, vp = '0, vo = '0;
  logic signed [15:0] o_scc, o_psg, o_opll, o_all;
  logic o_valid, o_busy, o_ovr;

  mmp_mix_sat #(.GAIN_SHIFT(GS)) dut (
    .i_CLK(clk), .i_RST(rst), .i_SMPL_STB(stb),
    .i_SCC(scc), .i_PSG(psg), .i_OPLL(opll),
    .i_VOL_SCC(vs), .i_VOL_PSG(vp), .i_VOL_OPLL(vo),
    .i_MUTE(mute), .i_OVR_CLR(ovr_clr),
    .o_SCC(o_scc), .o_PSG(o_psg), .o_OPLL(o_opll), .o_ALL(o_all),
    .o_VALID(o_valid), .o_BUSY(o_busy), .o_OVR(o_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] s, p, o;
    logic [4:0] gs, gp, go;
    logic mute;
  } smp_t;

  typedef struct {
    logic signed [15:0] all, s, p, o;
    int t;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int cyc = 0, n_pass = 0, n_tot = 0;
  logic rst_seen = 1'b1, started = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: integer weighted sum, floor-divide by 2^GS, clamp, mute.
  function automatic logic signed [15:0] model(input smp_t x);
    int g[3], v[3], acc, r;
    g[0] = (x.gs > 16) ? 16 : int'(x.gs);
    g[1] = (x.gp > 16) ? 16 : int'(x.gp);
    g[2] = (x.go > 16) ? 16 : int'(x.go);
    v[0] = x.s; v[1] = x.p; v[2] = x.o;
    acc = 0;
    for (int i = 0; i < 3; i++) acc += v[i] * g[i];
    r = acc >>> GS;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (x.mute) r = 0;
    return 16'(r);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        last.all = '0; last.s = '0; last.p = '0; last.o = '0;
      end
      if (o_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("all",  o_all,  e.all);
          check("scc",  o_scc,  e.s);
          check("psg",  o_psg,  e.p);
          check("opll", o_opll, e.o);
          check("latency", cyc, e.t);
          check("busy_at_valid", o_busy, 1'b0);
          last = e;
        end
      end else begin
        check("hold", {o_all, o_scc, o_psg, o_opll}, {last.all, last.s, last.p, last.o});
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic smp_t rnd_smp();
    smp_t x;
    int k;
    k = $urandom_range(0, 3);
    x.s = (k == 0) ? 16'sh7fff : (k == 1) ? 16'sh8000 : 16'($urandom);
    x.p = 16'($urandom);
    x.o = (k == 0) ? 16'sh7fff : (k == 1) ? 16'sh8000 : 16'($urandom);
    x.gs = 5'($urandom_range(0, 31));
    x.gp = 5'($urandom_range(0, 31));
    x.go = 5'($urandom_range(0, 31));
    x.mute = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  task automatic scramble;
    smp_t j;
    j = rnd_smp();
    scc = j.s; psg = j.p; opll = j.o; vs = j.gs; vp = j.gp; vo = j.go; mute = j.mute;
  endtask

  // Present x for one edge (E0); returns just after E0.
  task automatic send(input smp_t x, input bit push);
    exp_t e;
    scc = x.s; psg = x.p; opll = x.o; vs = x.gs; vp = x.gp; vo = x.go; mute = x.mute;
    stb = 1'b1;
    if (push) begin
      e.all = model(x); e.s = x.s; e.p = x.p; e.o = x.o; e.t = cyc + 5;
      q.push_back(e);
    end
    tick;
    stb = 1'b0;
    scramble();
    check("busy_after_accept", o_busy, 1'b1);
  endtask

  task automatic mix(input smp_t x);
    send(x, 1'b1);
    repeat (4) tick;
  endtask

  function automatic smp_t mk(input int s, p, o, input int gs, gp, go, input bit m);
    smp_t x;
    x.s = 16'(s); x.p = 16'(p); x.o = 16'(o);
    x.gs = 5'(gs); x.gp = 5'(gp); x.go = 5'(go); x.mute = m;
    return x;
  endfunction

  initial begin
    last.all = '0; last.s = '0; last.p = '0; last.o = '0; last.t = 0;
    repeat (2) tick;
    rst = 1'b0;
    started = 1'b1;
    check("rst_outs", {o_all, o_scc, o_psg, o_opll}, 64'd0);
    check("rst_flags", {o_valid, o_busy, o_ovr}, 3'b000);

    // Directed cases
    mix(mk(1000, 2000, -500, 16, 16, 16, 0));
    mix(mk(32767, 32767, 32767, 16, 16, 16, 0));
    mix(mk(-32768, -32768, -32768, 16, 16, 16, 0));
    mix(mk(-1, 0, 0, 1, 0, 0, 0));
    mix(mk(100, 0, 0, 31, 0, 0, 0));
    mix(mk(1234, -555, 77, 16, 9, 20, 1));
    tick;
    check("ovr_idle", o_ovr, 1'b0);

    // Overrun: second strobe at E2 is dropped
    send(mk(300, 400, 500, 16, 16, 16, 0), 1'b1);
    tick;
    stb = 1'b1;
    tick;
    stb = 1'b0;
    check("ovr_set", o_ovr, 1'b1);
    repeat (2) tick;
    check("ovr_sticky", o_ovr, 1'b1);
    tick;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    check("ovr_clr", o_ovr, 1'b0);
    send(mk(-7, 8, 9, 3, 4, 5, 0), 1'b1);
    tick;
    stb = 1'b1; ovr_clr = 1'b1;
    tick;
    stb = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", o_ovr, 1'b1);
    repeat (2) tick;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    check("ovr_clr2", o_ovr, 1'b0);

    // Reset mid-mix (asserted for E2): no valid, outputs zero
    send(mk(5000, 5000, 5000, 16, 16, 16, 0), 1'b0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_mid_outs", {o_all, o_scc, o_psg, o_opll}, 64'd0);
    check("rst_mid_flags", {o_valid, o_busy, o_ovr}, 3'b000);
    repeat (4) tick;
    mix(mk(10, 20, 30, 16, 16, 16, 0));

    // Randomized, including back-to-back (gap 0)
    for (int i = 0; i < 60; i++) begin
      mix(rnd_smp());
      repeat ($urandom_range(0, 3)) tick;
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) tick;
    check("queue_drained", q.size(), 0);
    check("ovr_end", o_ovr, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mmp_mix_sat.md
MMP_MIX_SAT -- requirements
Module: mmp_mix_sat

Interface
REQ-001 Parameter: GAIN_SHIFT, default 4, right arithmetic shift applied to the gain-weighted sum (gain 16 = unity).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port: i_CLK  in  1  clock; all logic on the rising edge.
REQ-004 Port: i_RST  in  1  synchronous active-high reset.
REQ-005 Port: i_SMPL_STB  in  1  one-cycle pulse; new sample set available.
REQ-006 Port: i_SCC / i_PSG / i_OPLL  in  16 each  signed source samples.
REQ-007 Port: i_VOL_SCC / i_VOL_PSG / i_VOL_OPLL  in  5 each  unsigned gain (0..16).
REQ-008 Port: i_MUTE  in  1  forces the mixed result to 0.
REQ-009 Port: i_OVR_CLR  in  1  clears o_OVR.
REQ-010 Port: o_SCC / o_PSG / o_OPLL  out  16 each  signed latched source samples, aligned with o_ALL.
REQ-011 Port: o_ALL  out  16  signed saturated mix; feeds the DAC serializer's ALL input.
REQ-012 Port: o_VALID  out  1  one-cycle pulse; outputs updated.
REQ-013 Port: o_BUSY  out  1  high while a mix is in progress.
REQ-014 Port: o_OVR  out  1  sticky flag; a strobe arrived while busy.

Function
REQ-015 The block SHALL use a single shared signed multiplier, time-multiplexed by an FSM with states IDLE, MUL0, MUL1, MUL2, SAT.
REQ-016 IDLE with i_SMPL_STB=1 at edge E0: latch the three samples, three gains and i_MUTE, then go to MUL0.
REQ-017 MUL0 (edge E1): accumulator (24-bit signed) <= SCC*gain; MUL1 (E2): += PSG*gain; MUL2 (E3): += OPLL*gain; then go to SAT.
REQ-018 Gain values 17..31 SHALL be treated as 16; products SHALL be signed 16-bit x unsigned 5-bit (zero-extended).
REQ-019 SAT (edge E4): o_ALL <= clamp(acc >>> GAIN_SHIFT) to [-32768, 32767]; the shift floors toward minus infinity.
REQ-020 SAT: if latched mute=1, o_ALL <= 0 instead of the clamped value.
REQ-021 SAT: o_SCC/o_PSG/o_OPLL <= the latched samples; o_VALID=1 for exactly the cycle after E4; next state IDLE.
REQ-022 o_BUSY SHALL be 1 in MUL0..SAT and 0 in IDLE; a strobe at E5 SHALL be accepted, giving a latency of 4 edges.
REQ-023 A strobe during MUL0..SAT SHALL be ignored (latched data and pipeline unaffected) and SHALL set o_OVR.
REQ-024 o_OVR SHALL hold until i_OVR_CLR=1; if a clear and an overrun occur in the same cycle, the set wins.
REQ-025 Inputs changing after E0 SHALL NOT affect the result of the mix in progress.
REQ-026 Outputs SHALL hold their values between o_VALID pulses.

Reset
REQ-027 When i_RST=1 at a rising edge: state <= IDLE, accumulator and latches <= 0, o_SCC/o_PSG/o_OPLL/o_ALL <= 0, o_VALID/o_BUSY/o_OVR <= 0.
REQ-028 Reset during MUL0..SAT SHALL abort the mix with no o_VALID pulse; reset SHALL take priority over i_SMPL_STB.

Verification
REQ-029 Unity mix: SCC=1000, PSG=2000, OPLL=-500, all gains 16 -> o_ALL=2500 with o_VALID 4 edges after the strobe; o_SCC=1000, o_PSG=2000, o_OPLL=-500.
REQ-030 Saturation: all samples 32767, gains 16 -> o_ALL=32767; all samples -32768, gains 16 -> o_ALL=-32768.
REQ-031 Gain and rounding: SCC=-1 with gain 1, others gain 0 -> o_ALL=-1; SCC=100 with gain 31 -> o_ALL=100 (clamped to gain 16); i_MUTE=1 -> o_ALL=0.
REQ-032 Overrun: strobes at E0 and E2 -> one o_VALID carrying E0 data and o_OVR=1; i_OVR_CLR alone clears it; a clear coincident with a new overrun leaves o_OVR=1.
REQ-033 Back-to-back strobes at E0 and E5 -> two o_VALID pulses, o_OVR=0.
REQ-034 Reset at E2 of a mix -> no o_VALID pulse; all outputs 0; a strobe after reset release produces a correct mix.
